resonator_ddc_mix_round_out: RTL and testbench

//  Downstream of the 18s x 16s -> 34-bit DDC product multipliers. Per resonator sample it takes the four products
//  of (I + jQ) * (cos - j*sin), forms the complex sum and difference, and rounds and saturates to OUT_W bits.
//  It emits one packed IQ word per beat on an AXI-Stream-style master, with per-channel index and frame TLAST.
//  It also provides backpressure and a sticky saturation flag for status readback.

---
 rtl/resonator_ddc_mix_round_out.sv | 140 ++++++++++++++
 tb/tb_resonator_ddc_mix_round_out.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/resonator_ddc_mix_round_out.sv
`default_nettype none
// ============================================================================
// Module   : resonator_ddc_mix_round_out
// Brief    : Complex mix of DDC products, round/saturate, AXI-Stream output
//            with channel index, frame TLAST and sticky saturation flag.
// Revision : 1.0 - initial release
// ============================================================================
module resonator_ddc_mix_round_out #(
    parameter int PROD_W = 34,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 17,
    parameter int N_CHAN = 256,
    parameter int CH_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PROD_W-1:0]    p_ic,
    input  logic [PROD_W-1:0]    p_qs,
    input  logic [PROD_W-1:0]    p_qc,
    input  logic [PROD_W-1:0]    p_is,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [2*OUT_W-1:0]   m_tdata,
    output logic [CH_W-1:0]      m_tuser,
    output logic                 m_tlast,
    input  logic                 sat_clear,
    output logic                 sat_sticky
);

    localparam int c_RW = PROD_W + 2;
    localparam logic signed [c_RW-1:0] c_HALF =
        {{(c_RW-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [c_RW-1:0] c_MAX =
        {{(c_RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [c_RW-1:0] c_MIN =
        {{(c_RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [CH_W-1:0] c_LAST = CH_W'(N_CHAN - 1);

    // Returns {saturated, value}; rounds half toward +inf then clamps.
    function automatic logic [OUT_W:0] f_round_sat(input logic signed [PROD_W:0] s);
        logic signed [c_RW-1:0] r;
        r = ($signed({s[PROD_W], s}) + c_HALF) >>> SHIFT;
        if (r > c_MAX)
            f_round_sat = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        else if (r < c_MIN)
            f_round_sat = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        else
            f_round_sat = {1'b0, r[OUT_W-1:0]};
    endfunction

    logic                   r_s1_valid;
    logic signed [PROD_W:0] r_s1_i;
    logic signed [PROD_W:0] r_s1_q;
    logic                   r_s2_valid;
    logic [2*OUT_W-1:0]     r_tdata;
    logic [CH_W-1:0]        r_tuser;
    logic [CH_W-1:0]        r_ch;
    logic                   r_sat;

    logic                   w_hs;
    logic                   w_s2_load;
    logic                   w_s1_load;
    logic signed [PROD_W:0] w_si;
    logic signed [PROD_W:0] w_sq;
    logic [OUT_W:0]         w_ri;
    logic [OUT_W:0]         w_rq;
    logic                   w_sat_ev;
    logic [CH_W-1:0]        w_ch_inc;
    logic [CH_W-1:0]        w_ch_next;

    assign w_hs      = r_s2_valid & m_tready;
    assign w_s2_load = ~r_s2_valid | w_hs;
    assign w_s1_load = ~r_s1_valid | w_s2_load;
    assign in_ready  = w_s1_load;

    assign w_si = $signed({p_ic[PROD_W-1], p_ic}) + $signed({p_qs[PROD_W-1], p_qs});
    assign w_sq = $signed({p_qc[PROD_W-1], p_qc}) - $signed({p_is[PROD_W-1], p_is});

    assign w_ri     = f_round_sat(r_s1_i);
    assign w_rq     = f_round_sat(r_s1_q);
    assign w_sat_ev = w_s2_load & r_s1_valid & (w_ri[OUT_W] | w_rq[OUT_W]);

    // A beat loading S2 during a handshake takes the post-increment index.
    assign w_ch_inc  = (r_ch == c_LAST) ? '0 : r_ch + 1'b1;
    assign w_ch_next = w_hs ? w_ch_inc : r_ch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_i     <= '0;
            r_s1_q     <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_i <= w_si;
                r_s1_q <= w_sq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_tdata    <= '0;
            r_tuser    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_tdata <= {w_rq[OUT_W-1:0], w_ri[OUT_W-1:0]};
                r_tuser <= w_ch_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_ch <= '0;
        else
            r_ch <= w_ch_next;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_sat <= 1'b0;
        else if (w_sat_ev)
            r_sat <= 1'b1;
        else if (sat_clear)
            r_sat <= 1'b0;
    end

    assign m_tvalid   = r_s2_valid;
    assign m_tdata    = r_tdata;
    assign m_tuser    = r_tuser;
    assign m_tlast    = (r_tuser == c_LAST);
    assign sat_sticky = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_resonator_ddc_mix_round_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_resonator_ddc_mix_round_out
// Brief    : Directed scoreboard bench for resonator_ddc_mix_round_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_resonator_ddc_mix_round_out;

    localparam int c_NCH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] p_ic, p_qs, p_qc, p_is;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic [1:0]  m_tuser;
    logic        m_tlast;
    logic        sat_clear;
    logic        sat_sticky;

    resonator_ddc_mix_round_out #(
        .PROD_W(34), .OUT_W(16), .SHIFT(17), .N_CHAN(c_NCH), .CH_W(2)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .p_ic(p_ic), .p_qs(p_qs), .p_qc(p_qc), .p_is(p_is),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tuser(m_tuser), .m_tlast(m_tlast),
        .sat_clear(sat_clear), .sat_sticky(sat_sticky)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [34:0] sb_q[$];
    int   exp_ch = 0;
    logic saw_block = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] mdl(input longint s);
        longint r;
        r = (s + 64'sd65536) >>> 17;
        if (r > 64'sd32767)  return {1'b1, 16'h7FFF};
        if (r < -64'sd32768) return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    // Output monitor: pops the scoreboard on each handshake, checks stall stability.
    logic        prev_stall = 1'b0;
    logic [34:0] prev_beat;
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall && m_tvalid)
                chk("stall_stable", {29'd0, m_tlast, m_tuser, m_tdata}, {29'd0, prev_beat});
            if (in_valid && !in_ready)
                saw_block = 1'b1;
            if (m_tvalid && m_tready) begin
                if (sb_q.size() == 0)
                    chk("unexpected_beat", 64'd1, 64'd0);
                else
                    chk("beat", {29'd0, m_tlast, m_tuser, m_tdata}, {29'd0, sb_q.pop_front()});
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tuser, m_tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input longint a, input longint b, input longint c, input longint d);
        int cnt;
        logic [16:0] ri, rq;
        p_ic = a[33:0];
        p_qs = b[33:0];
        p_qc = c[33:0];
        p_is = d[33:0];
        in_valid = 1'b1;
        @(negedge clk);
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
        end else begin
            ri = mdl(a + b);
            rq = mdl(c - d);
            sb_q.push_back({(exp_ch == c_NCH - 1), 2'(exp_ch), rq[15:0], ri[15:0]});
            exp_ch = (exp_ch + 1) % c_NCH;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cnt = 0;
        while (sb_q.size() != 0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("drain_left", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic longint rnd33();
        return (longint'($urandom) - 64'sd2147483648) * 2;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; m_tready = 1'b1; sat_clear = 1'b0;
        p_ic = '0; p_qs = '0; p_qc = '0; p_is = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_tdata), 64'd0);
        chk("rst_tuser", 64'(m_tuser), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_sticky", 64'(sat_sticky), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic mix and two-stage latency
        send(3 <<< 17, 2 <<< 17, 5 <<< 17, 1 <<< 17);
        chk("lat_tvalid_early", 64'(m_tvalid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_tvalid", 64'(m_tvalid), 64'd1);
        chk("lat_tdata", 64'(m_tdata), 64'h0000_0000_0004_0005);
        chk("lat_tuser", 64'(m_tuser), 64'd0);
        drain();

        // Rounding boundaries on I
        send(64'sd65536, 0, 0, 0);
        send(64'sd65535, 0, 0, 0);
        send(-64'sd65536, 0, 0, 0);
        send(-64'sd65537, 0, 0, 0);
        drain();
        chk("sticky_no_sat", 64'(sat_sticky), 64'd0);

        // Saturation both directions, clear, and set-wins-over-clear
        send((64'sd1 <<< 33) - 1, (64'sd1 <<< 33) - 1, -(64'sd1 <<< 33), (64'sd1 <<< 33) - 1);
        drain();
        chk("sticky_set", 64'(sat_sticky), 64'd1);
        sat_clear = 1'b1;
        @(posedge clk);
        #1;
        sat_clear = 1'b0;
        chk("sticky_cleared", 64'(sat_sticky), 64'd0);
        sat_clear = 1'b1;
        send((64'sd1 <<< 33) - 1, (64'sd1 <<< 33) - 1, 0, 0);
        chk("sticky_clear_hold", 64'(sat_sticky), 64'd0);
        @(posedge clk);
        #1;
        chk("sticky_set_wins", 64'(sat_sticky), 64'd1);
        sat_clear = 1'b0;
        drain();

        // Ten beats with a five-cycle downstream stall
        saw_block = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(longint'(i) * 70001 * 3, longint'(i) <<< 18, -(longint'(i) * 123457), 64'sd98304);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                m_tready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        drain();
        chk("in_ready_dropped", 64'(saw_block), 64'd1);

        // Back-to-back frame wrap with mixed-sign products
        for (int i = 0; i < 8; i++)
            send(rnd33(), rnd33(), rnd33(), rnd33());
        drain();

        // Reset with both stages full
        send((64'sd1 <<< 33) - 1, (64'sd1 <<< 33) - 1, 0, 0);
        drain();
        m_tready = 1'b0;
        send(64'sd1 <<< 20, 0, 0, 0);
        send(64'sd1 <<< 21, 0, 0, 0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_sticky", 64'(sat_sticky), 64'd1);
        reset = 1'b1;
        sb_q.delete();
        exp_ch = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_mid_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_mid_sticky", 64'(sat_sticky), 64'd0);
        m_tready = 1'b1;
        send(7 <<< 17, 0, 0, 3 <<< 17);
        drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
